// File: rtl/aclk_controller.sv
// ---------------------------------------------------------------------------
// aclk_controller
//
// Purpose:
//   Moore FSM for an alarm clock front panel. It sequences keypad digit entry
//   (one shift strobe per key press), commits the entered digits to either the
//   alarm register or the time counter, shows the stored alarm while the alarm
//   button is held, and abandons digit entry after TIMEOUT_SEC idle seconds.
//
// Handshake / strobe semantics:
//   There is no valid/ready pair here. Every input is a level or a one-cycle
//   pulse sampled on the rising clock edge. Every output is decoded from the
//   registered state only, so an input sampled at edge N shows up on the
//   outputs just after edge N. shift, load_new_a, load_new_c and reset_count
//   are one-cycle strobes; downstream logic acts on them at the next edge.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   one_second    in   one-cycle pulse once per second
//   key           in   [3:0] keypad code, NOKEY = idle, anything else = digit
//   alarm_button  in   level, alarm button held
//   time_button   in   level, time button held
//   show_alarm    out  display shows the stored alarm time
//   show_new_time out  display shows the digits being entered
//   shift         out  strobe: key register shifts in the current key
//   load_new_a    out  strobe: alarm register loads the entered digits
//   load_new_c    out  strobe: time counter loads the entered digits
//   reset_count   out  strobe: seconds prescaler clears
//   state_o       out  [2:0] current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module aclk_controller #(
    parameter logic [3:0] NOKEY       = 4'd10,
    parameter int         TIMEOUT_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       show_alarm,
    output logic       show_new_time,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count,
    output logic [2:0] state_o
);

    // State encoding
    localparam logic [2:0] SHOW_TIME        = 3'd0;
    localparam logic [2:0] KEY_STORED       = 3'd1;
    localparam logic [2:0] KEY_WAITED       = 3'd2;
    localparam logic [2:0] KEY_ENTRY        = 3'd3;
    localparam logic [2:0] SHOW_ALARM       = 3'd4;
    localparam logic [2:0] SET_ALARM_TIME   = 3'd5;
    localparam logic [2:0] SET_CURRENT_TIME = 3'd6;

    // Idle-seconds counter sized to hold the value TIMEOUT_SEC itself.
    localparam int         CNT_W    = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_SEC);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_state;
    logic             key_pressed;
    logic             timeout;

    assign key_pressed = (key != NOKEY);
    assign timed_state = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

    // The TIMEOUT_SEC-th pulse seen in a timed state ends entry on that edge.
    assign timeout = timed_state && one_second && (cnt_q == CNT_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME: begin
                if (alarm_button)     state_d = SHOW_ALARM;
                else if (key_pressed) state_d = KEY_STORED;
            end
            // Leaves after exactly one cycle so each press shifts once.
            KEY_STORED: state_d = KEY_WAITED;
            // A held key parks here and never re-shifts.
            KEY_WAITED: begin
                if (!key_pressed)     state_d = KEY_ENTRY;
                else if (timeout)     state_d = SHOW_TIME;
            end
            // Buttons beat a new key, and everything beats the timeout.
            KEY_ENTRY: begin
                if (alarm_button)     state_d = SET_ALARM_TIME;
                else if (time_button) state_d = SET_CURRENT_TIME;
                else if (key_pressed) state_d = KEY_STORED;
                else if (timeout)     state_d = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button)    state_d = SHOW_TIME;
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    // Counter: runs only while staying in one timed state. Any state change,
    // including WAITED<->ENTRY and entry from KEY_STORED, restarts it at 0.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) ||
            !((state_d == KEY_WAITED) || (state_d == KEY_ENTRY))) begin
            cnt_d = '0;
        end else if (one_second && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SHOW_TIME;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        show_alarm    = 1'b0;
        show_new_time = 1'b0;
        shift         = 1'b0;
        load_new_a    = 1'b0;
        load_new_c    = 1'b0;
        reset_count   = 1'b0;
        case (state_q)
            KEY_STORED: begin
                shift         = 1'b1;
                show_new_time = 1'b1;
            end
            KEY_WAITED:       show_new_time = 1'b1;
            KEY_ENTRY:        show_new_time = 1'b1;
            SHOW_ALARM:       show_alarm    = 1'b1;
            SET_ALARM_TIME:   load_new_a    = 1'b1;
            SET_CURRENT_TIME: begin
                load_new_c    = 1'b1;
                reset_count   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule
